chimera_bypass_switch_ctrl: RTL



---
 rtl/chimera_bypass_switch_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/chimera_bypass_switch_ctrl.sv
// rtl/chimera_bypass_switch_ctrl.sv - per-cluster drain-safe wide-memory bypass mode switch
module chimera_bypass_switch_ctrl #(
   parameter int unsigned NumClusters    = 5,
   parameter int unsigned MaxOutstanding = 16,
   parameter int unsigned SettleCycles   = 2,
   parameter int unsigned TimeoutCycles  = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] bypass_req_i,
   input  logic [NumClusters-1:0] aw_hs_i,
   input  logic [NumClusters-1:0] b_hs_i,
   input  logic [NumClusters-1:0] ar_hs_i,
   input  logic [NumClusters-1:0] r_last_hs_i,
   input  logic                   clr_err_i,
   output logic [NumClusters-1:0] bypass_o,
   output logic [NumClusters-1:0] stall_aw_o,
   output logic [NumClusters-1:0] stall_ar_o,
   output logic [NumClusters-1:0] busy_o,
   output logic [NumClusters-1:0] timeout_o,
   output logic [NumClusters-1:0] underflow_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned TmrW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntMax     = CntW'(MaxOutstanding);
   localparam logic [TmrW-1:0] TmrMax     = TmrW'(TimeoutCycles);
   localparam logic [TmrW-1:0] TmrHit     = TmrW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam logic [3:0]      SettleLast = 4'((SettleCycles > 0) ? SettleCycles - 1 : 0);

   typedef enum logic [1:0] {
      ST_STABLE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2,
      ST_SETTLE = 2'd3
   } state_e;

   for (genvar c = 0; c < int'(NumClusters); c++) begin : g_cluster
      state_e          state_q, state_d;
      logic [CntW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
      logic [TmrW-1:0] tmr_q, tmr_d;
      logic [3:0]      settle_q, settle_d;
      logic            bypass_q, bypass_d;
      logic            stall_aw_q, stall_aw_d, stall_ar_q, stall_ar_d;
      logic            busy_q, busy_d;
      logic            tmo_q, tmo_d, unf_q, unf_d;
      logic            w_unf, r_unf, tmo_hit, fsm_stall;

      // Outstanding write/read tracking; a completion at zero flags underflow but an increment still lands
      always_comb begin
         wcnt_d = wcnt_q;
         w_unf  = 1'b0;
         case ({aw_hs_i[c], b_hs_i[c]})
            2'b10: if (wcnt_q != CntMax) wcnt_d = wcnt_q + CntW'(1);
            2'b01: if (wcnt_q == '0) w_unf = 1'b1; else wcnt_d = wcnt_q - CntW'(1);
            2'b11: if (wcnt_q == '0) begin w_unf = 1'b1; wcnt_d = CntW'(1); end
            default: ;
         endcase
         rcnt_d = rcnt_q;
         r_unf  = 1'b0;
         case ({ar_hs_i[c], r_last_hs_i[c]})
            2'b10: if (rcnt_q != CntMax) rcnt_d = rcnt_q + CntW'(1);
            2'b01: if (rcnt_q == '0) r_unf = 1'b1; else rcnt_d = rcnt_q - CntW'(1);
            2'b11: if (rcnt_q == '0) begin r_unf = 1'b1; rcnt_d = CntW'(1); end
            default: ;
         endcase
      end

      // Mode FSM: drain both directions before flipping, then hold stalls while the adapter settles
      always_comb begin
         state_d  = state_q;
         tmr_d    = tmr_q;
         settle_d = settle_q;
         tmo_hit  = 1'b0;
         case (state_q)
            ST_STABLE: begin
               if (bypass_req_i[c] != bypass_q) begin
                  state_d = ST_DRAIN;
                  tmr_d   = '0;
               end
            end
            ST_DRAIN: begin
               if (tmr_q != TmrMax) tmr_d = tmr_q + TmrW'(1);
               if ((TimeoutCycles != 0) && (tmr_q == TmrHit)) tmo_hit = 1'b1;
               if (bypass_req_i[c] == bypass_q) begin
                  state_d = ST_STABLE;
               end else if ((wcnt_q == '0) && (rcnt_q == '0) && !aw_hs_i[c] && !ar_hs_i[c]) begin
                  state_d = ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               settle_d = '0;
               state_d  = (SettleCycles == 0) ? ST_STABLE : ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_q == SettleLast) state_d = ST_STABLE;
               else                        settle_d = settle_q + 4'd1;
            end
            default: state_d = ST_STABLE;
         endcase
      end

      // Next values of the registered outputs; the mode flips on the edge that enters SWITCH
      always_comb begin
         bypass_d = bypass_q;
         if ((state_q == ST_DRAIN) && (state_d == ST_SWITCH)) bypass_d = bypass_req_i[c];
         fsm_stall  = (state_d != ST_STABLE);
         stall_aw_d = fsm_stall | (wcnt_d == CntMax);
         stall_ar_d = fsm_stall | (rcnt_d == CntMax);
         busy_d     = (state_d != ST_STABLE);
         tmo_d      = (tmo_q & ~clr_err_i) | tmo_hit;
         unf_d      = (unf_q & ~clr_err_i) | w_unf | r_unf;
      end

      // FSM state, drain timer and settle counter
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q  <= ST_STABLE;
            tmr_q    <= '0;
            settle_q <= '0;
         end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            settle_q <= settle_d;
         end
      end

      // Counters and output registers
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            bypass_q   <= 1'b0;
            stall_aw_q <= 1'b0;
            stall_ar_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            unf_q      <= 1'b0;
         end else begin
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            bypass_q   <= bypass_d;
            stall_aw_q <= stall_aw_d;
            stall_ar_q <= stall_ar_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            unf_q      <= unf_d;
         end
      end

      assign bypass_o[c]    = bypass_q;
      assign stall_aw_o[c]  = stall_aw_q;
      assign stall_ar_o[c]  = stall_ar_q;
      assign busy_o[c]      = busy_q;
      assign timeout_o[c]   = tmo_q;
      assign underflow_o[c] = unf_q;
   end

endmodule
